// File: rtl/vc_dd_pkg.sv
// ---------------------------------------------------------------------------
// vc_dd_pkg
// Shared definitions for the domain-tagged val/rdy muxes.
//   DBITS_DEF  : default domain-tag width
//   domain_t   : domain tag type at the default width
//   DOMAIN_*   : well-known domain tag encodings
//   wrap_inc   : (idx + 1) mod n for channel/pointer indices
// ---------------------------------------------------------------------------
package vc_dd_pkg;

    localparam int DBITS_DEF = 2;

    typedef logic [DBITS_DEF-1:0] domain_t;

    localparam domain_t DOMAIN_NS  = 2'd0;
    localparam domain_t DOMAIN_S   = 2'd1;
    localparam domain_t DOMAIN_DBG = 2'd2;

    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/vc_rr_arb_n.sv
// ---------------------------------------------------------------------------
// vc_rr_arb_n
// N-way round-robin arbiter. The search for a requester starts at the
// priority pointer and wraps from p_nin-1 to 0. The grant vector is purely
// combinational on reqs and the pointer (one-hot or all-zero). The pointer
// moves to one past the winner whenever en is high and something is granted.
// Ports:
//   clk    : clock, rising edge
//   reset  : asynchronous, active-high; pointer returns to 0
//   reqs   : per-channel request
//   en     : downstream can accept this cycle; qualifies pointer advance
//   grants : one-hot grant (or all zero)
// ---------------------------------------------------------------------------
module vc_rr_arb_n
    import vc_dd_pkg::*;
#(
    parameter int p_nin = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [p_nin-1:0] reqs,
    input  logic             en,
    output logic [p_nin-1:0] grants
);

    localparam int PW = (p_nin > 1) ? $clog2(p_nin) : 1;

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_win;
    logic [PW-1:0] w_c;
    logic          w_any;
    int            w_idx;

    // Walk the channels in priority order starting at the pointer; the first
    // requester found wins.
    always_comb begin
        grants = '0;
        w_win  = '0;
        w_any  = 1'b0;
        w_idx  = 0;
        w_c    = '0;
        for (int k = 0; k < p_nin; k++) begin
            w_idx = int'(r_ptr) + k;
            if (w_idx >= p_nin) begin
                w_idx = w_idx - p_nin;
            end
            w_c = PW'(w_idx);
            if (!w_any && reqs[w_c]) begin
                grants[w_c] = 1'b1;
                w_win       = w_c;
                w_any       = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (en && w_any) begin
            r_ptr <= PW'(wrap_inc(int'(w_win), p_nin));
        end
    end

endmodule

// File: rtl/vc_mux_n_dd_pipe.sv
// ---------------------------------------------------------------------------
// vc_mux_n_dd_pipe
// p_nin-input val/rdy mux with round-robin arbitration and a one-entry
// registered output stage. Each channel's domain tag travels with its message
// and the index of the supplying channel is reported on out_sel.
//
// Handshake: a transfer happens on any edge where val and rdy are both high
// on the same channel. The output stage loads whenever it is empty or being
// drained in the same cycle (go = !out_val || out_rdy), so a stream runs at
// one message per cycle. in_rdy never depends on in_msg/in_domain.
//
// Optional build macro VC_MUX_DD_SCRUB_EN: when defined, a drain with no
// refill clears out_msg and out_domain so no data of a previous domain stays
// visible while out_val is low. Handshake timing is the same either way.
//
// Ports:
//   clk, reset  : clock (rising edge), asynchronous active-high reset
//   in_val      : per-channel valid            [p_nin]
//   in_rdy      : per-channel ready (<= 1 hot) [p_nin]
//   in_msg      : packed messages, ch i at [i*p_nbits +: p_nbits]
//   in_domain   : packed tags, ch i at [i*p_dbits +: p_dbits]
//   out_val     : output register holds a message
//   out_rdy     : downstream accepts the message
//   out_msg     : registered message
//   out_domain  : registered domain tag of out_msg
//   out_sel     : channel index that supplied out_msg
// ---------------------------------------------------------------------------
module vc_mux_n_dd_pipe
    import vc_dd_pkg::*;
#(
    parameter int  p_nbits   = 32,
    parameter int  p_nin     = 4,
    parameter int  p_dbits   = DBITS_DEF,
    localparam int p_selbits = $clog2(p_nin)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [p_nin-1:0]         in_val,
    output logic [p_nin-1:0]         in_rdy,
    input  logic [p_nin*p_nbits-1:0] in_msg,
    input  logic [p_nin*p_dbits-1:0] in_domain,
    output logic                     out_val,
    input  logic                     out_rdy,
    output logic [p_nbits-1:0]       out_msg,
    output logic [p_dbits-1:0]       out_domain,
    output logic [p_selbits-1:0]     out_sel
);

    logic [p_nin-1:0]     w_grant;
    logic                 w_go;
    logic                 w_fire;
    logic [p_nbits-1:0]   w_msg;
    logic [p_dbits-1:0]   w_dom;
    logic [p_selbits-1:0] w_sel;

    assign w_go = !out_val || out_rdy;

    vc_rr_arb_n #(
        .p_nin (p_nin)
    ) u_arb (
        .clk    (clk),
        .reset  (reset),
        .reqs   (in_val),
        .en     (w_go),
        .grants (w_grant)
    );

    // A grant implies the channel is valid, so any in_rdy bit is a fire.
    // Reset gating keeps in_rdy low while the block is held in reset.
    assign in_rdy = w_grant & {p_nin{w_go & ~reset}};
    assign w_fire = |in_rdy;

    // Grant is one-hot, so picking the single granted channel needs no
    // priority encoding.
    always_comb begin
        w_msg = '0;
        w_dom = '0;
        w_sel = '0;
        for (int i = 0; i < p_nin; i++) begin
            if (w_grant[i]) begin
                w_msg = in_msg[i*p_nbits +: p_nbits];
                w_dom = in_domain[i*p_dbits +: p_dbits];
                w_sel = p_selbits'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_val    <= 1'b0;
            out_msg    <= '0;
            out_domain <= p_dbits'(DOMAIN_NS);
            out_sel    <= '0;
        end else if (w_fire) begin
            // Covers simultaneous drain and refill: the new message replaces
            // the old one and out_val stays high.
            out_val    <= 1'b1;
            out_msg    <= w_msg;
            out_domain <= w_dom;
            out_sel    <= w_sel;
        end else if (out_val && out_rdy) begin
            out_val <= 1'b0;
`ifdef VC_MUX_DD_SCRUB_EN
            out_msg    <= '0;
            out_domain <= p_dbits'(DOMAIN_NS);
`else
            out_msg    <= out_msg;
            out_domain <= out_domain;
`endif
        end
    end

endmodule

// File: doc/vc_mux_n_dd_pipe.md
Name: vc_mux_n_dd_pipe

Overview:
- Parametrised successor to the two-input domain-tagged mux.
- Selects one of p_nin val/rdy input channels by round-robin arbitration. Each channel carries a message and its security-domain tag.
- Registers the winner in a one-entry output stage, so the domain tag travels with the data.
- Sits between multiple domain-tagged requesters (cores, DMA) and a shared downstream port such as a memory or network injection point.

Parameters:
- p_nbits, 32, message width in bits.
- p_nin, 4, number of input channels; legal range is 2 or more.
- p_dbits, 2, domain-tag width in bits.
- p_selbits, $clog2(p_nin), width of the out_sel index. This is derived and must not be overridden.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_val  in  p_nin  per-channel valid.
- in_rdy  out  p_nin  per-channel ready.
- in_msg  in  p_nin*p_nbits  packed messages; channel i occupies bits [i*p_nbits +: p_nbits].
- in_domain  in  p_nin*p_dbits  packed domain tags; channel i occupies bits [i*p_dbits +: p_dbits].
- out_val  out  1  output register holds a message.
- out_rdy  in  1  downstream accepts the message.
- out_msg  out  p_nbits  registered message.
- out_domain  out  p_dbits  registered domain tag of out_msg.
- out_sel  out  p_selbits  index of the channel that supplied out_msg.

Behaviour:
- Reset values (asynchronous):
  - out_val=0, out_msg=0, out_domain=0, out_sel=0.
  - Arbiter priority pointer=0, so channel 0 has highest priority.
  - in_rdy=0 while reset is asserted.
- Output stage load enable: go = !out_val || out_rdy. This gives a bubble-free pipeline at 1 message per cycle.
- Arbitration:
  - Round-robin among channels with in_val=1.
  - Search starts at the priority pointer and wraps from p_nin-1 to 0.
  - grant is one-hot or all-zero. It is purely combinational on in_val and the pointer.
- in_rdy[i] = grant[i] & go.
  - At most one in_rdy bit is high per cycle.
  - in_rdy never depends on in_msg or in_domain.
- Transfer: in_val[i] & in_rdy[i] is a fire. On the next edge:
  - out_msg <= channel i message.
  - out_domain <= channel i tag.
  - out_sel <= i.
  - out_val <= 1.
  - Priority pointer <= (i+1) mod p_nin.
- Drain without refill: out_val & out_rdy with no fire sets out_val <= 0 on the next edge. out_msg, out_domain and out_sel hold.
- Stall: out_val & !out_rdy holds every register, holds the pointer and drives in_rdy all-zero.
- Latency: a fire in cycle t produces out_val=1 with the message in cycle t+1.
- Pointer behaviour:
  - The pointer advances only on a fire; no fire means no change.
  - A single requester may fire every cycle.
  - Wrap-around: a grant to p_nin-1 sets the pointer to 0.
- Simultaneous drain and fire: the new message replaces the old one in the same edge, and out_val stays 1.
- Reset mid-transfer: any held message is discarded immediately. Upstream must re-present it.
- Upstream protocol requirement: in_msg and in_domain stay stable while in_val is high and no fire has occurred. The block does not check this.

Optional Feature:
- Macro: VC_MUX_DD_SCRUB_EN.
- When defined:
  - On drain without refill, out_msg and out_domain are cleared to 0.
  - On a fire whose tag differs from the current out_domain while out_val=0, the load itself is unchanged.
  - The net effect is that no stale data of one domain remains visible on out_msg when out_val=0.
- When undefined: out_msg and out_domain hold their last values after a drain, as described in Behaviour.
- Handshake timing is identical with and without the macro.

Decomposition:
- Shared package vc_dd_pkg:
  - DOMAIN_NS=2'd0, DOMAIN_S=2'd1, DOMAIN_DBG=2'd2.
  - A typedef for the domain tag, p_dbits wide.
  - A localparam for the default tag width.
- Sub-module vc_rr_arb_n (parameter p_nin):
  - Inputs clk, reset, reqs, en.
  - Output grants.
  - Holds the priority pointer and advances it on en & |grants.
- The top level instantiates the arbiter, the output register and the scrub logic.

Test Plan:
- Reset: assert reset mid-cycle while out_val=1 -> out_val, out_msg and out_domain go to 0 immediately, and in_rdy=0.
- Round-robin: p_nin=4, all in_val=1, msgs 0xA0..0xA3, tags 0,1,0,1, out_rdy=1 -> out_sel sequence 0,1,2,3,0, one message per cycle, and out_domain matches each tag.
- Stall: out_rdy=0 for 3 cycles with all inputs valid -> in_rdy=0000, out_msg held at 0xA1, and the pointer is unchanged; on release, channel 2 is granted next.
- Sparse wrap: only in_val[3] and in_val[0] high, pointer=1 -> channel 3 is granted, then channel 0, confirming the pointer wraps past p_nin-1.
- Drain: single message 0x55 with tag 1, then no inputs -> out_val falls one cycle after the accept. Without VC_MUX_DD_SCRUB_EN, out_msg=0x55; with VC_MUX_DD_SCRUB_EN, out_msg=0 and out_domain=0.
- Parameter sweep: p_nin=2,3,8 and p_nbits=1,64 with random val/rdy -> scoreboard shows no loss or duplication, every msg/tag pair is preserved, and in_rdy is never more than one-hot.
